// File: rtl/booth_mac_acc.sv
// ---------------------------------------------------------------------------
// booth_mac_acc
//
// Dot-product accumulator that sits behind the 4x4 signed Booth multiplier.
// It takes signed 8-bit products over a valid/ready handshake and sums
// VEC_LEN consecutive products into a signed ACC_W-bit accumulator. Each
// finished sum is presented on an output valid/ready handshake, together
// with a sticky signed-overflow flag for that vector.
//
// Parameters:
//   ACC_W   - accumulator / output width in bits (>= 8)
//   VEC_LEN - number of products summed per output (>= 1)
//
// Ports:
//   clk          - clock, all state changes on the rising edge
//   rst          - asynchronous active-low reset
//   clear_i      - synchronous abort, drops the partial or presented sum
//   prod_valid_i - product_i is valid this cycle
//   product_i    - signed 8-bit product
//   prod_ready_o - block accepts a product this cycle (ACCUM state)
//   acc_o        - signed accumulated sum
//   acc_valid_o  - acc_o holds a completed vector sum (OUT state)
//   acc_ready_i  - downstream accepts acc_o
//   overflow_o   - signed overflow seen in the current / presented vector
//   count_o      - products accepted in the current vector
//
// Build option:
//   BOOTH_MAC_SATURATE_EN - when defined, an overflowing add clamps the
//   accumulator to the most positive / most negative ACC_W value instead
//   of wrapping. overflow_o is raised in both builds.
// ---------------------------------------------------------------------------
module booth_mac_acc #(
    parameter int ACC_W   = 16,
    parameter int VEC_LEN = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear_i,
    input  logic                           prod_valid_i,
    input  logic [7:0]                     product_i,
    output logic                           prod_ready_o,
    output logic [ACC_W-1:0]               acc_o,
    output logic                           acc_valid_o,
    input  logic                           acc_ready_i,
    output logic                           overflow_o,
    output logic [$clog2(VEC_LEN+1)-1:0]   count_o
);

    localparam int CNT_W = $clog2(VEC_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_OUT   = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               ovf_reg, ovf_next;

    // Sign-extend the product: a size cast of a signed operand replicates
    // the sign bit, which also covers ACC_W == 8 without a zero-width field.
    logic signed [7:0]  prod_s;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   sum_wrap;
    logic [ACC_W-1:0]   sum_res;
    logic               add_ovf;

    assign prod_s   = product_i;
    assign prod_ext = ACC_W'(prod_s);
    assign sum_wrap = acc_reg + prod_ext;

    // Signed overflow: operands agree in sign, result disagrees.
    assign add_ovf = (acc_reg[ACC_W-1] == prod_ext[ACC_W-1]) &&
                     (sum_wrap[ACC_W-1] != acc_reg[ACC_W-1]);

`ifdef BOOTH_MAC_SATURATE_EN
    // On overflow both operands share a sign, so the product sign picks
    // the rail to clamp to.
    always_comb begin
        sum_res = sum_wrap;
        if (add_ovf) begin
            if (prod_ext[ACC_W-1]) begin
                sum_res = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                sum_res = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
    end
`else
    assign sum_res = sum_wrap;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_ACCUM;
            acc_reg   <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        count_next = count_reg;
        ovf_next   = ovf_reg;

        if (clear_i) begin
            // Abort wins over any handshake in the same cycle.
            state_next = ST_ACCUM;
            acc_next   = '0;
            count_next = '0;
            ovf_next   = 1'b0;
        end else begin
            case (state_reg)
                ST_ACCUM: begin
                    if (prod_valid_i) begin
                        acc_next   = sum_res;
                        count_next = CNT_W'(count_reg + 1'b1);
                        if (add_ovf) begin
                            ovf_next = 1'b1;
                        end
                        if (count_reg == LAST_CNT) begin
                            state_next = ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    // Products are not accepted in the handshake cycle;
                    // the next vector starts on the following edge.
                    if (acc_ready_i) begin
                        state_next = ST_ACCUM;
                        acc_next   = '0;
                        count_next = '0;
                        ovf_next   = 1'b0;
                    end
                end
                default: begin
                    state_next = ST_ACCUM;
                end
            endcase
        end
    end

    assign prod_ready_o = (state_reg == ST_ACCUM);
    assign acc_valid_o  = (state_reg == ST_OUT);
    assign acc_o        = acc_reg;
    assign overflow_o   = ovf_reg;
    assign count_o      = count_reg;

endmodule

// File: tb/tb_booth_mac_acc.sv
// ---------------------------------------------------------------------------
// tb_booth_mac_acc
//
// Directed bench for booth_mac_acc. Three instances share the clock, reset
// and input stimulus:
//   dut_a : ACC_W=16, VEC_LEN=4  (main function, backpressure, clear, reset)
//   dut_b : ACC_W=8,  VEC_LEN=4  (overflow)
//   dut_c : ACC_W=16, VEC_LEN=1  (single-product vectors)
// Every scenario starts with a clear so all instances begin from a known
// empty vector; only the instance a scenario targets is checked.
// ---------------------------------------------------------------------------
module tb_booth_mac_acc;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        pv;
    logic [7:0]  prod;
    logic        ar;

    logic        pr_a, av_a, ov_a;
    logic [15:0] acc_a;
    logic [2:0]  cnt_a;

    logic        pr_b, av_b, ov_b;
    logic [7:0]  acc_b;
    logic [2:0]  cnt_b;

    logic        pr_c, av_c, ov_c;
    logic [15:0] acc_c;
    logic [0:0]  cnt_c;

    int n_checks;
    int n_fail;

    booth_mac_acc #(.ACC_W(16), .VEC_LEN(4)) dut_a (
        .clk(clk), .rst(rst), .clear_i(clear), .prod_valid_i(pv),
        .product_i(prod), .prod_ready_o(pr_a), .acc_o(acc_a),
        .acc_valid_o(av_a), .acc_ready_i(ar), .overflow_o(ov_a),
        .count_o(cnt_a)
    );

    booth_mac_acc #(.ACC_W(8), .VEC_LEN(4)) dut_b (
        .clk(clk), .rst(rst), .clear_i(clear), .prod_valid_i(pv),
        .product_i(prod), .prod_ready_o(pr_b), .acc_o(acc_b),
        .acc_valid_o(av_b), .acc_ready_i(ar), .overflow_o(ov_b),
        .count_o(cnt_b)
    );

    booth_mac_acc #(.ACC_W(16), .VEC_LEN(1)) dut_c (
        .clk(clk), .rst(rst), .clear_i(clear), .prod_valid_i(pv),
        .product_i(prod), .prod_ready_o(pr_c), .acc_o(acc_c),
        .acc_valid_o(av_c), .acc_ready_i(ar), .overflow_o(ov_c),
        .count_o(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_vector();
        pv = 1'b0; ar = 1'b0; clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; clear = 1'b0; pv = 1'b0; prod = 8'd0; ar = 1'b0;
        #12;
        n_checks++;
        if (acc_a !== 16'd0 || cnt_a !== 3'd0 || av_a !== 1'b0 || ov_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: acc=%0d cnt=%0d valid=%b ovf=%b, required 0 0 0 0", acc_a, cnt_a, av_a, ov_a);
        end
        rst = 1'b1;
        cyc();
        n_checks++;
        if (pr_a !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: prod_ready=%b, required 1", pr_a);
        end
        $display("reset done");
    endtask

    // Plan items 1 and 2: back-to-back vector then backpressure.
    task automatic test_basic_and_backpressure();
        start_vector();
        pv = 1'b1;
        prod = 8'd20;      cyc();
        prod = 8'(-6);     cyc();
        prod = 8'd49;      cyc();
        prod = 8'(-56);    cyc();
        $display("vector a done: acc=%0d valid=%b cnt=%0d", $signed(acc_a), av_a, cnt_a);
        n_checks++;
        if (av_a !== 1'b1 || acc_a !== 16'd7) begin
            n_fail++;
            $display("FAIL basic_sum: valid=%b acc=%0d, required 1 7", av_a, $signed(acc_a));
        end
        n_checks++;
        if (ov_a !== 1'b0 || pr_a !== 1'b0 || cnt_a !== 3'd4) begin
            n_fail++;
            $display("FAIL basic_flags: ovf=%b ready=%b cnt=%0d, required 0 0 4", ov_a, pr_a, cnt_a);
        end
        prod = 8'd9;
        ar = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_checks++;
            if (av_a !== 1'b1 || acc_a !== 16'd7 || cnt_a !== 3'd4 || pr_a !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: valid=%b acc=%0d cnt=%0d ready=%b, required 1 7 4 0", i, av_a, $signed(acc_a), cnt_a, pr_a);
            end
        end
        ar = 1'b1;
        cyc();
        ar = 1'b0;
        $display("handshake a: acc=%0d cnt=%0d", $signed(acc_a), cnt_a);
        n_checks++;
        if (av_a !== 1'b0 || cnt_a !== 3'd0 || acc_a !== 16'd0 || pr_a !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake_no_bypass: valid=%b cnt=%0d acc=%0d ready=%b, required 0 0 0 1", av_a, cnt_a, $signed(acc_a), pr_a);
        end
        cyc();
        pv = 1'b0;
        n_checks++;
        if (cnt_a !== 3'd1 || acc_a !== 16'd9) begin
            n_fail++;
            $display("FAIL next_vector_accept: cnt=%0d acc=%0d, required 1 9", cnt_a, $signed(acc_a));
        end
    endtask

    // Plan item 3: clear mid-vector discards the simultaneous product.
    task automatic test_clear();
        start_vector();
        pv = 1'b1;
        prod = 8'd10; cyc();
        prod = 8'd12; cyc();
        n_checks++;
        if (cnt_a !== 3'd2 || acc_a !== 16'd22) begin
            n_fail++;
            $display("FAIL clear_partial: cnt=%0d acc=%0d, required 2 22", cnt_a, $signed(acc_a));
        end
        clear = 1'b1; prod = 8'd5;
        cyc();
        clear = 1'b0;
        $display("clear a: acc=%0d cnt=%0d", $signed(acc_a), cnt_a);
        n_checks++;
        if (cnt_a !== 3'd0 || acc_a !== 16'd0 || ov_a !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_zero: cnt=%0d acc=%0d ovf=%b, required 0 0 0", cnt_a, $signed(acc_a), ov_a);
        end
        prod = 8'd1;
        for (int i = 0; i < 4; i++) cyc();
        pv = 1'b0;
        $display("vector a done: acc=%0d valid=%b", $signed(acc_a), av_a);
        n_checks++;
        if (av_a !== 1'b1 || acc_a !== 16'd4) begin
            n_fail++;
            $display("FAIL clear_then_sum: valid=%b acc=%0d, required 1 4", av_a, $signed(acc_a));
        end
        // Clear while presenting drops the sum even with ready high.
        clear = 1'b1; ar = 1'b1;
        cyc();
        clear = 1'b0; ar = 1'b0;
        n_checks++;
        if (av_a !== 1'b0 || acc_a !== 16'd0 || cnt_a !== 3'd0) begin
            n_fail++;
            $display("FAIL clear_in_out: valid=%b acc=%0d cnt=%0d, required 0 0 0", av_a, $signed(acc_a), cnt_a);
        end
    endtask

    // Plan item 4: 8-bit accumulator overflow.
    task automatic test_overflow();
        logic [7:0] exp_acc;
`ifdef BOOTH_MAC_SATURATE_EN
        exp_acc = 8'd127;
`else
        exp_acc = 8'h80;
`endif
        start_vector();
        pv = 1'b1;
        prod = 8'd64; cyc();
        prod = 8'd64; cyc();
        n_checks++;
        if (ov_b !== 1'b1 || acc_b !== exp_acc) begin
            n_fail++;
            $display("FAIL overflow_mid: ovf=%b acc=%0d, required 1 %0d", ov_b, $signed(acc_b), $signed(exp_acc));
        end
        prod = 8'd0; cyc();
        prod = 8'd0; cyc();
        pv = 1'b0;
        $display("vector b done: acc=%0d ovf=%b valid=%b", $signed(acc_b), ov_b, av_b);
        n_checks++;
        if (av_b !== 1'b1 || ov_b !== 1'b1 || acc_b !== exp_acc) begin
            n_fail++;
            $display("FAIL overflow_final: valid=%b ovf=%b acc=%0d, required 1 1 %0d", av_b, ov_b, $signed(acc_b), $signed(exp_acc));
        end
        ar = 1'b1;
        cyc();
        ar = 1'b0;
        n_checks++;
        if (ov_b !== 1'b0 || av_b !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_clear: ovf=%b valid=%b, required 0 0", ov_b, av_b);
        end
    endtask

    // Plan item 5: asynchronous reset between edges.
    task automatic test_reset_mid_vector();
        start_vector();
        pv = 1'b1;
        prod = 8'd5;
        for (int i = 0; i < 3; i++) cyc();
        pv = 1'b0;
        n_checks++;
        if (cnt_a !== 3'd3 || acc_a !== 16'd15) begin
            n_fail++;
            $display("FAIL pre_reset: cnt=%0d acc=%0d, required 3 15", cnt_a, $signed(acc_a));
        end
        #2 rst = 1'b0;
        #1;
        $display("async reset: acc=%0d cnt=%0d valid=%b", $signed(acc_a), cnt_a, av_a);
        n_checks++;
        if (acc_a !== 16'd0 || cnt_a !== 3'd0 || av_a !== 1'b0 || ov_a !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: acc=%0d cnt=%0d valid=%b ovf=%b, required 0 0 0 0", $signed(acc_a), cnt_a, av_a, ov_a);
        end
        #1 rst = 1'b1;
        cyc();
        n_checks++;
        if (pr_a !== 1'b1 || cnt_a !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b cnt=%0d, required 1 0", pr_a, cnt_a);
        end
        pv = 1'b1;
        prod = 8'(-8);
        for (int i = 0; i < 4; i++) cyc();
        pv = 1'b0;
        $display("vector a done: acc=%0d valid=%b", $signed(acc_a), av_a);
        n_checks++;
        if (av_a !== 1'b1 || acc_a !== 16'hFFE0 || ov_a !== 1'b0) begin
            n_fail++;
            $display("FAIL neg_sum: valid=%b acc=%0d ovf=%b, required 1 -32 0", av_a, $signed(acc_a), ov_a);
        end
    endtask

    // Plan item 6: VEC_LEN=1, ready held high.
    task automatic test_back_to_back();
        start_vector();
        ar = 1'b1;
        pv = 1'b1;
        prod = 8'd49;
        cyc();
        $display("vector c done: acc=%0d valid=%b", $signed(acc_c), av_c);
        n_checks++;
        if (av_c !== 1'b1 || acc_c !== 16'd49 || cnt_c !== 1'b1 || pr_c !== 1'b0) begin
            n_fail++;
            $display("FAIL vl1_first: valid=%b acc=%0d cnt=%0d ready=%b, required 1 49 1 0", av_c, $signed(acc_c), cnt_c, pr_c);
        end
        prod = 8'(-64);
        cyc();
        n_checks++;
        if (av_c !== 1'b0 || pr_c !== 1'b1 || acc_c !== 16'd0) begin
            n_fail++;
            $display("FAIL vl1_gap: valid=%b ready=%b acc=%0d, required 0 1 0", av_c, pr_c, $signed(acc_c));
        end
        cyc();
        pv = 1'b0;
        $display("vector c done: acc=%0d valid=%b", $signed(acc_c), av_c);
        n_checks++;
        if (av_c !== 1'b1 || acc_c !== 16'hFFC0) begin
            n_fail++;
            $display("FAIL vl1_second: valid=%b acc=%0d, required 1 -64", av_c, $signed(acc_c));
        end
        cyc();
        ar = 1'b0;
        n_checks++;
        if (av_c !== 1'b0 || cnt_c !== 1'b0) begin
            n_fail++;
            $display("FAIL vl1_drain: valid=%b cnt=%0d, required 0 0", av_c, cnt_c);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic_and_backpressure();
        test_clear();
        test_overflow();
        test_reset_mid_vector();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_mac_acc.md
Name: booth_mac_acc

Overview:
- Downstream consumer of the 4x4 signed Booth multiplier.
- Accepts a stream of signed 8-bit products over a valid/ready handshake and sums VEC_LEN consecutive products into a wide signed accumulator (dot product).
- Presents each finished sum on an output valid/ready handshake, with a per-vector overflow flag.
- Sits between the multiplier result and the result-consuming logic.

Parameters:
- ACC_W, 16, accumulator/output width in bits; must be >= 8.
- VEC_LEN, 4, number of products summed per output; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- clear_i  input  1  synchronous abort: discard the partial sum, restart the vector.
- prod_valid_i  input  1  product_i is valid this cycle.
- product_i  input  8  signed product from the multiplier.
- prod_ready_o  output  1  block can accept a product this cycle.
- acc_o  output  ACC_W  signed accumulated sum.
- acc_valid_o  output  1  acc_o holds a completed vector sum.
- acc_ready_i  input  1  downstream accepts acc_o.
- overflow_o  output  1  a signed overflow occurred in the current or presented vector.
- count_o  output  $clog2(VEC_LEN+1)  products accepted in the current vector.

Behaviour:
- Reset (rst low, asynchronous):
  - State ACCUM; acc_o = 0, count_o = 0, acc_valid_o = 0, overflow_o = 0.
  - prod_ready_o = 1 once rst deasserts.
- States: ACCUM and OUT.
- ACCUM:
  - prod_ready_o = 1, acc_valid_o = 0.
  - Product accepted when prod_valid_i && prod_ready_o.
  - On accept: product_i is sign-extended to ACC_W and added to acc; count increments.
  - Add result width is ACC_W; default is two's-complement wrap.
  - Overflow: both operands have the same sign and the result sign differs. Sets overflow_o (sticky until the next vector start).
  - Accept that brings count to VEC_LEN: acc holds the final sum; next cycle state = OUT.
  - Latency: last product accepted at edge N gives acc_valid_o = 1 after edge N, with the final sum on acc_o.
- OUT:
  - acc_valid_o = 1, prod_ready_o = 0; prod_valid_i ignored (upstream must hold).
  - acc_o, overflow_o, count_o (= VEC_LEN) held stable until acc_valid_o && acc_ready_i.
  - On handshake: acc = 0, count = 0, overflow_o = 0, state = ACCUM.
  - A product may be accepted no earlier than the cycle after the handshake; no bypass.
- clear_i:
  - Highest priority after reset.
  - At the edge: acc = 0, count = 0, overflow_o = 0, state = ACCUM, acc_valid_o = 0.
  - A product offered in the same cycle is discarded.
  - In OUT, the presented sum is dropped even if acc_ready_i is high.
- Boundary cases:
  - VEC_LEN = 1: every accepted product goes directly to OUT.
  - Count never exceeds VEC_LEN.
  - prod_valid_i low cycles simply stall the accumulation.
  - Products of -8 * -8 = 64 and -8 * 7 = -56 are handled by sign extension only; no special casing.

Optional Feature:
- Macro BOOTH_MAC_SATURATE_EN.
- Defined:
  - On overflow, acc clamps to +(2^(ACC_W-1))-1 or -(2^(ACC_W-1)) according to the operand sign.
  - Later adds in the same vector proceed from the clamped value.
  - overflow_o is still set.
- Undefined: two's-complement wrap as above; overflow_o flags only.

Test Plan:
1. ACC_W=16, VEC_LEN=4; products 20, -6, 49, -56 with back-to-back valid → acc_valid_o one cycle after the 4th accept; acc_o = 7; overflow_o = 0; prod_ready_o = 0 while OUT.
2. Backpressure: in OUT, hold acc_ready_i = 0 for 5 cycles while prod_valid_i = 1 with product 9 → acc_o stays 7, no product accepted. Release acc_ready_i → next vector accepts 9 with count_o = 1.
3. clear_i asserted after 2 accepts (10, 12), with prod_valid_i = 1 (product 5) in the same cycle → acc_o = 0, count_o = 0; 5 discarded. Next 4 products 1, 1, 1, 1 → acc_o = 4.
4. Overflow with ACC_W=8, VEC_LEN=4; products 64, 64, 0, 0 → overflow_o = 1. acc_o = -128 (wrap build) or 127 (BOOTH_MAC_SATURATE_EN build). overflow_o clears after the output handshake.
5. Reset mid-vector: assert rst low asynchronously between edges after 3 accepts → all outputs 0 immediately, prod_ready_o = 1 after release. A new vector of 4 × (-8) → acc_o = -32.
6. VEC_LEN=1: products 49 then -64 with acc_ready_i = 1 held → two outputs, 49 then -64, each one cycle after its accept; accept rate one product per 2 cycles.
